// File: rtl/axis_window_serializer.sv
// axis_window_serializer: buffers 128-bit windowed words in a FIFO
// and emits each as four 32-bit AXI4-Stream beats, LSW first.
module axis_window_serializer #(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [127:0]             s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [FIFO_DEPTH_LOG2:0] sts_fill,
    output logic [31:0]              sts_drop
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL =
        (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE =
        (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE =
        FIFO_DEPTH_LOG2'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [127:0]               mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic [127:0]               hold_q;
    logic [1:0]                 beat_q;
    logic [31:0]                drop_q;

    logic fifo_full;
    logic fifo_empty;
    logic wr_en;
    logic pop;
    logic hs;
    logic last_hs;

    // Fullness uses the registered count: a same-cycle pop does not
    // make room for the incoming word.
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign wr_en      = s_axis_tvalid & ~fifo_full;
    assign hs         = m_axis_tvalid & m_axis_tready;
    assign last_hs    = hs & (beat_q == 2'd3);

    // Output state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_hs) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset, pointers guard validity.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= s_axis_tdata;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Holding register and beat counter for the word being sent.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_q <= '0;
            beat_q <= '0;
        end else if (pop) begin
            hold_q <= mem[rd_ptr_q];
            beat_q <= '0;
        end else if (hs) begin
            beat_q <= beat_q + 2'd1;
        end
    end

    // Saturating counter of words lost to a full FIFO.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_q <= '0;
        end else if (s_axis_tvalid && fifo_full && (drop_q != '1)) begin
            drop_q <= drop_q + 32'd1;
        end
    end

    // Beat select from the holding register, zero when idle.
    always_comb begin
        m_axis_tdata = '0;
        if (state_q == SEND) begin
            unique case (beat_q)
                2'd0: m_axis_tdata = hold_q[31:0];
                2'd1: m_axis_tdata = hold_q[63:32];
                2'd2: m_axis_tdata = hold_q[95:64];
                2'd3: m_axis_tdata = hold_q[127:96];
                default: m_axis_tdata = '0;
            endcase
        end
    end

    assign m_axis_tvalid = (state_q == SEND);
    assign m_axis_tlast  = (state_q == SEND) && (beat_q == 2'd3);
    assign sts_fill      = count_q;
    assign sts_drop      = drop_q;

endmodule

// File: tb/tb_axis_window_serializer.sv
// tb_axis_window_serializer: random and directed stimulus checked
// against a queue-based reference model of the serializer.
module tb_axis_window_serializer;

    localparam int LOG2  = 4;
    localparam int DEPTH = 1 << LOG2;

    logic          aclk;
    logic          areset;
    logic [127:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [LOG2:0] sts_fill;
    logic [31:0]   sts_drop;

    int n_chk;
    int n_pass;

    logic [127:0] mq[$];
    logic [31:0]  mb[$];
    longint       mdrop;

    axis_window_serializer #(.FIFO_DEPTH_LOG2(LOG2)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .sts_fill      (sts_fill),
        .sts_drop      (sts_drop)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mb.delete();
        mdrop = 0;
    endtask

    // One clock edge of the reference model, using the inputs the
    // DUT sampled on that edge.
    task automatic model_step();
        bit hs;
        bit pop;
        bit full;
        logic [127:0] w;
        hs   = (mb.size() > 0) && m_axis_tready;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) &&
               ((mb.size() == 0) || (hs && mb.size() == 1));
        if (hs) void'(mb.pop_front());
        if (pop) begin
            w = mq.pop_front();
            for (int i = 0; i < 4; i++) mb.push_back(w[32*i +: 32]);
        end
        if (s_axis_tvalid) begin
            if (full) begin
                if (mdrop < 64'hFFFFFFFF) mdrop++;
            end else begin
                mq.push_back(s_axis_tdata);
            end
        end
    endtask

    task automatic compare();
        chk("tvalid", m_axis_tvalid, mb.size() > 0);
        chk("tdata", m_axis_tdata, (mb.size() > 0) ? mb[0] : 32'd0);
        chk("tlast", m_axis_tlast, mb.size() == 1);
        chk("fill", sts_fill, mq.size());
        chk("drop", sts_drop, mdrop[31:0]);
    endtask

    task automatic cycle(input logic v, input logic [127:0] d,
                         input logic r);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = r;
        @(posedge aclk);
        if (!areset) model_step();
        #1;
        compare();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] w;

    initial begin
        n_chk = 0;
        n_pass = 0;
        model_clear();
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        compare();
        areset = 1'b0;

        // Single word, sink always ready.
        cycle(1, 128'h44444444_33333333_22222222_11111111, 1);
        cycle(0, '0, 1);
        chk("single_beat0", m_axis_tdata, 32'h11111111);
        repeat (6) cycle(0, '0, 1);

        // Three back-to-back words.
        repeat (3) cycle(1, rnd128(), 1);
        chk("three_fill", sts_fill, 2);
        repeat (16) cycle(0, '0, 1);

        // Stall for 10 cycles while beat 1 is presented.
        cycle(1, rnd128(), 1);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        repeat (10) cycle(0, '0, 0);
        repeat (6) cycle(0, '0, 1);

        // Overflow: 20 words into a stalled sink.
        repeat (20) cycle(1, rnd128(), 0);
        chk("ovf_fill", sts_fill, 16);
        chk("ovf_drop", sts_drop, 3);
        repeat (17 * 4 + 4) cycle(0, '0, 1);

        // Full FIFO with a pop on the same edge as an arriving word.
        repeat (17) cycle(1, rnd128(), 0);
        repeat (3) cycle(0, '0, 1);
        chk("fp_last", m_axis_tlast, 1);
        cycle(1, rnd128(), 1);
        chk("fp_fill", sts_fill, 15);
        chk("fp_drop", sts_drop, 4);
        repeat (16 * 4 + 4) cycle(0, '0, 1);

        // Asynchronous reset while beat 2 is on the bus.
        cycle(1, rnd128(), 1);
        repeat (3) cycle(0, '0, 1);
        #2;
        areset = 1'b1;
        #1;
        model_clear();
        compare();
        @(posedge aclk);
        #1;
        compare();
        areset = 1'b0;
        w = rnd128();
        cycle(1, w, 1);
        cycle(0, '0, 1);
        chk("rst_beat0", m_axis_tdata, w[31:0]);
        repeat (6) cycle(0, '0, 1);

        // Random traffic, moderate and then heavy input rate.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 30, rnd128(),
                  $urandom_range(0, 99) < 75);
        end
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 90, rnd128(),
                  $urandom_range(0, 99) < 20);
        end
        repeat (100) cycle(0, '0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
